// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch stage and the
// 32x8 program ROM it drives.
package fetch_pkg;

  localparam int FETCH_AW = 5;
  localparam int FETCH_DW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Bundle between the fetch unit, the program ROM pins and the decoder handshake.
// FETCH_BOOT_LOADER_EN adds the boot-loader inputs load_en / load_data.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int AW = FETCH_AW,
  parameter int DW = FETCH_DW
) ();

  logic          run;
  logic          stall;
  logic          branch_en;
  logic [AW-1:0] branch_addr;
  logic [DW-1:0] rom_q;
  logic [AW-1:0] rom_addr;
  logic          rom_we;
  logic [DW-1:0] rom_d;
  logic          rom_init;
  logic [AW-1:0] pc;
  logic [DW-1:0] ir;
  logic          ir_valid;
`ifdef FETCH_BOOT_LOADER_EN
  logic          load_en;
  logic [DW-1:0] load_data;

  modport master (
    input  run, stall, branch_en, branch_addr, rom_q, load_en, load_data,
    output rom_addr, rom_we, rom_d, rom_init, pc, ir, ir_valid
  );

  modport slave (
    output run, stall, branch_en, branch_addr, rom_q, load_en, load_data,
    input  rom_addr, rom_we, rom_d, rom_init, pc, ir, ir_valid
  );
`else
  modport master (
    input  run, stall, branch_en, branch_addr, rom_q,
    output rom_addr, rom_we, rom_d, rom_init, pc, ir, ir_valid
  );

  modport slave (
    output run, stall, branch_en, branch_addr, rom_q,
    input  rom_addr, rom_we, rom_d, rom_init, pc, ir, ir_valid
  );
`endif

endinterface

// File: rtl/fetch_pc_counter.sv
// AW-bit address register with synchronous reset, parallel load and a
// wrapping increment; used for the program counter and the loader pointer.
module fetch_pc_counter #(
  parameter int AW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] q
);

  logic [AW-1:0] r_q;

  // Priority: reset, then load, then increment (wraps modulo 2^AW).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= {AW{1'b0}};
    end else if (load) begin
      r_q <= load_val;
    end else if (inc) begin
      r_q <= r_q + AW'(1);
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM address/control, instruction register with a
// valid/stall handshake and branch redirect. Boot loader: FETCH_BOOT_LOADER_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int AW = FETCH_AW,
  parameter int DW = FETCH_DW
) (
  input  logic   clock,
  input  logic   reset,
  fetch_if.master bus
);

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] w_ir_nxt;
  logic          r_ir_valid;
  logic          w_ir_valid_nxt;
  logic          r_boot;
  logic          r_rom_init;
  logic          w_pc_load;
  logic          w_pc_inc;
  logic [AW-1:0] w_pc;
  logic          w_load_blk;

  fetch_pc_counter #(.AW(AW)) u_pc (
    .clock    (clock),
    .reset    (reset),
    .load     (w_pc_load),
    .load_val (bus.branch_addr),
    .inc      (w_pc_inc),
    .q        (w_pc)
  );

`ifdef FETCH_BOOT_LOADER_EN
  logic          w_load_act;
  logic [AW-1:0] w_lp;

  // Loader writes only while idle and after the ROM preload pulse.
  assign w_load_act = (r_state == IDLE) && bus.load_en && !r_rom_init;
  assign w_load_blk = bus.load_en;

  fetch_pc_counter #(.AW(AW)) u_lp (
    .clock    (clock),
    .reset    (reset),
    .load     (1'b0),
    .load_val ({AW{1'b0}}),
    .inc      (w_load_act),
    .q        (w_lp)
  );

  assign bus.rom_we   = w_load_act;
  assign bus.rom_addr = w_load_act ? w_lp : w_pc;
  assign bus.rom_d    = w_load_act ? bus.load_data : {DW{1'b0}};
`else
  assign w_load_blk   = 1'b0;
  assign bus.rom_we   = 1'b0;
  assign bus.rom_addr = w_pc;
  assign bus.rom_d    = {DW{1'b0}};
`endif

  // Next-state and datapath control; branch outranks stall and normal flow.
  always_comb begin
    w_state_nxt    = r_state;
    w_ir_nxt       = r_ir;
    w_ir_valid_nxt = r_ir_valid;
    w_pc_load      = 1'b0;
    w_pc_inc       = 1'b0;
    if (bus.branch_en) begin
      w_pc_load      = 1'b1;
      w_ir_valid_nxt = 1'b0;
      if (r_state == IDLE) begin
        w_state_nxt = IDLE;
      end else if (bus.run) begin
        w_state_nxt = ISSUE;
      end else begin
        w_state_nxt = IDLE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.run && !r_rom_init && !w_load_blk) begin
            w_state_nxt = ISSUE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        ISSUE: begin
          if (r_ir_valid && bus.stall) begin
            w_state_nxt = ISSUE;
          end else begin
            w_ir_valid_nxt = 1'b0;
            w_state_nxt    = bus.run ? CAPTURE : IDLE;
          end
        end
        CAPTURE: begin
          w_ir_nxt       = bus.rom_q;
          w_ir_valid_nxt = 1'b1;
          w_pc_inc       = 1'b1;
          w_state_nxt    = ISSUE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, instruction register and the one-shot ROM preload pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ir       <= {DW{1'b0}};
      r_ir_valid <= 1'b0;
      r_boot     <= 1'b1;
      r_rom_init <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_valid <= w_ir_valid_nxt;
      r_boot     <= 1'b0;
      r_rom_init <= r_boot;
    end
  end

  assign bus.pc       = w_pc;
  assign bus.ir       = r_ir;
  assign bus.ir_valid = r_ir_valid;
  assign bus.rom_init = r_rom_init;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a fetch-level reference model; includes a behavioural 32x8 ROM.
module tb_fetch_unit;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  fetch_if #(.AW(5), .DW(8)) bus ();

  fetch_unit #(.AW(5), .DW(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // ROM image is rom[i] = i, restored on every preload pulse.
  logic [7:0] rom_mem [32];
  always @(posedge clock) begin
    if (bus.rom_init) begin
      for (int i = 0; i < 32; i++) rom_mem[i] <= 8'(i);
    end else if (bus.rom_we) begin
      rom_mem[bus.rom_addr] <= bus.rom_d;
    end
    bus.rom_q <= rom_mem[bus.rom_addr];
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.run = 1'b0; bus.stall = 1'b0; bus.branch_en = 1'b0;
    cyc(); cyc();
    n_checks++; if (bus.pc !== 5'd0) begin n_fail++; $display("FAIL reset_pc got=%0d exp=0", bus.pc); end
    n_checks++; if (bus.ir !== 8'h00) begin n_fail++; $display("FAIL reset_ir got=%h exp=00", bus.ir); end
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.ir_valid); end
    n_checks++; if (bus.rom_init !== 1'b0) begin n_fail++; $display("FAIL reset_rom_init got=%b exp=0", bus.rom_init); end
    n_checks++; if (bus.rom_we !== 1'b0) begin n_fail++; $display("FAIL reset_rom_we got=%b exp=0", bus.rom_we); end
    n_checks++; if (bus.rom_d !== 8'h00) begin n_fail++; $display("FAIL reset_rom_d got=%h exp=00", bus.rom_d); end
    n_checks++; if (bus.rom_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rom_addr got=%0d exp=0", bus.rom_addr); end
  endtask

  task automatic test_sequential();
    reset = 1'b0; bus.run = 1'b0;
    cyc();
    n_checks++; if (bus.rom_init !== 1'b1) begin n_fail++; $display("FAIL seq_init_pulse got=%b exp=1", bus.rom_init); end
    bus.run = 1'b1;
    cyc();
    n_checks++; if (bus.rom_init !== 1'b0) begin n_fail++; $display("FAIL seq_init_drop got=%b exp=0", bus.rom_init); end
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL seq_idle_valid got=%b exp=0", bus.ir_valid); end
    cyc();
    n_checks++; if (bus.ir_valid !== 1'b0 || bus.pc !== 5'd0) begin n_fail++; $display("FAIL seq_issue got valid=%b pc=%0d exp valid=0 pc=0", bus.ir_valid, bus.pc); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_checks++; if (bus.ir_valid !== 1'b0 || bus.pc !== 5'(k)) begin n_fail++; $display("FAIL seq_capture%0d got valid=%b pc=%0d exp valid=0 pc=%0d", k, bus.ir_valid, bus.pc, k); end
      cyc();
      n_checks++; if (bus.ir !== 8'(k) || bus.ir_valid !== 1'b1 || bus.pc !== 5'(k + 1)) begin n_fail++; $display("FAIL seq_ir%0d got ir=%h valid=%b pc=%0d exp ir=%h valid=1 pc=%0d", k, bus.ir, bus.ir_valid, bus.pc, k, k + 1); end
    end
  endtask

  task automatic test_stall();
    cyc(); cyc(); cyc(); cyc();
    n_checks++; if (bus.ir !== 8'h05 || bus.ir_valid !== 1'b1) begin n_fail++; $display("FAIL stall_pre got ir=%h valid=%b exp ir=05 valid=1", bus.ir, bus.ir_valid); end
    bus.stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_checks++; if (bus.ir !== 8'h05 || bus.ir_valid !== 1'b1 || bus.pc !== 5'd6) begin n_fail++; $display("FAIL stall_hold%0d got ir=%h valid=%b pc=%0d exp ir=05 valid=1 pc=6", k, bus.ir, bus.ir_valid, bus.pc); end
    end
    bus.stall = 1'b0;
    cyc();
    n_checks++; if (bus.ir_valid !== 1'b0 || bus.pc !== 5'd6) begin n_fail++; $display("FAIL stall_release got valid=%b pc=%0d exp valid=0 pc=6", bus.ir_valid, bus.pc); end
    cyc();
    n_checks++; if (bus.ir !== 8'h06 || bus.ir_valid !== 1'b1 || bus.pc !== 5'd7) begin n_fail++; $display("FAIL stall_next got ir=%h valid=%b pc=%0d exp ir=06 valid=1 pc=7", bus.ir, bus.ir_valid, bus.pc); end
  endtask

  task automatic test_branch_capture();
    bus.branch_en = 1'b1; bus.branch_addr = 5'd3;
    cyc();
    n_checks++; if (bus.pc !== 5'd3 || bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL br_issue got pc=%0d valid=%b exp pc=3 valid=0", bus.pc, bus.ir_valid); end
    bus.branch_en = 1'b0;
    cyc();
    bus.branch_en = 1'b1; bus.branch_addr = 5'h0A;
    cyc();
    n_checks++; if (bus.pc !== 5'h0A || bus.ir_valid !== 1'b0 || bus.ir !== 8'h06) begin n_fail++; $display("FAIL br_capture got pc=%0d valid=%b ir=%h exp pc=10 valid=0 ir=06", bus.pc, bus.ir_valid, bus.ir); end
    bus.branch_en = 1'b0;
    cyc();
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL br_no_valid got=%b exp=0", bus.ir_valid); end
    cyc();
    n_checks++; if (bus.ir !== 8'h0A || bus.ir_valid !== 1'b1 || bus.pc !== 5'h0B) begin n_fail++; $display("FAIL br_target got ir=%h valid=%b pc=%0d exp ir=0a valid=1 pc=11", bus.ir, bus.ir_valid, bus.pc); end
  endtask

  task automatic test_wrap();
    int a;
    bus.branch_en = 1'b1; bus.branch_addr = 5'd30;
    cyc();
    bus.branch_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      a = (30 + j) % 32;
      cyc();
      n_checks++; if (bus.pc !== 5'(a) || bus.rom_addr !== 5'(a)) begin n_fail++; $display("FAIL wrap_addr%0d got pc=%0d rom_addr=%0d exp %0d", j, bus.pc, bus.rom_addr, a); end
      cyc();
      n_checks++; if (bus.ir !== 8'(a) || bus.ir_valid !== 1'b1 || bus.pc !== 5'((a + 1) % 32)) begin n_fail++; $display("FAIL wrap_ir%0d got ir=%h valid=%b pc=%0d exp ir=%h valid=1 pc=%0d", j, bus.ir, bus.ir_valid, bus.pc, a, (a + 1) % 32); end
    end
  endtask

  task automatic test_run_drop_reset();
    bus.branch_en = 1'b1; bus.branch_addr = 5'h10;
    cyc();
    bus.branch_en = 1'b0; bus.run = 1'b0;
    cyc();
    n_checks++; if (bus.pc !== 5'h10 || bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL drop_idle got pc=%0d valid=%b exp pc=16 valid=0", bus.pc, bus.ir_valid); end
    cyc();
    n_checks++; if (bus.pc !== 5'h10 || bus.rom_addr !== 5'h10 || bus.ir !== 8'h01) begin n_fail++; $display("FAIL drop_hold got pc=%0d rom_addr=%0d ir=%h exp pc=16 rom_addr=16 ir=01", bus.pc, bus.rom_addr, bus.ir); end
    bus.run = 1'b1;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    n_checks++; if (bus.pc !== 5'd0 || bus.ir !== 8'h00 || bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset got pc=%0d ir=%h valid=%b exp pc=0 ir=00 valid=0", bus.pc, bus.ir, bus.ir_valid); end
    reset = 1'b0; bus.run = 1'b0;
    cyc();
    n_checks++; if (bus.rom_init !== 1'b1) begin n_fail++; $display("FAIL mid_reset_init got=%b exp=1", bus.rom_init); end
    cyc();
  endtask

`ifdef FETCH_BOOT_LOADER_EN
  task automatic test_loader();
    bus.load_en = 1'b1; bus.load_data = 8'hAA; bus.run = 1'b1;
    #1;
    n_checks++; if (bus.rom_we !== 1'b1 || bus.rom_addr !== 5'd0 || bus.rom_d !== 8'hAA) begin n_fail++; $display("FAIL load0 got we=%b addr=%0d d=%h exp we=1 addr=0 d=aa", bus.rom_we, bus.rom_addr, bus.rom_d); end
    cyc();
    bus.load_data = 8'hBB;
    #1;
    n_checks++; if (bus.rom_we !== 1'b1 || bus.rom_addr !== 5'd1 || bus.rom_d !== 8'hBB) begin n_fail++; $display("FAIL load1 got we=%b addr=%0d d=%h exp we=1 addr=1 d=bb", bus.rom_we, bus.rom_addr, bus.rom_d); end
    cyc();
    bus.load_en = 1'b0;
    #1;
    n_checks++; if (bus.rom_we !== 1'b0 || bus.rom_d !== 8'h00 || bus.rom_addr !== 5'd0) begin n_fail++; $display("FAIL load_off got we=%b d=%h addr=%0d exp we=0 d=00 addr=0", bus.rom_we, bus.rom_d, bus.rom_addr); end
    cyc(); cyc(); cyc();
    n_checks++; if (bus.ir !== 8'hAA || bus.ir_valid !== 1'b1) begin n_fail++; $display("FAIL load_ir0 got ir=%h valid=%b exp ir=aa valid=1", bus.ir, bus.ir_valid); end
    cyc(); cyc();
    n_checks++; if (bus.ir !== 8'hBB || bus.ir_valid !== 1'b1 || bus.pc !== 5'd2) begin n_fail++; $display("FAIL load_ir1 got ir=%h valid=%b pc=%0d exp ir=bb valid=1 pc=2", bus.ir, bus.ir_valid, bus.pc); end
    bus.run = 1'b0;
  endtask
`endif

  // Reference: a fetch is an address presented for one cycle, whose ROM word
  // (rom[a] = a) lands in ir one cycle later; phase 0 idle, 1 address out, 2 data back.
  task automatic test_random();
    logic [4:0] m_pc;
    logic [7:0] m_ir;
    logic       m_v, m_init, m_boot, n_init;
    int         m_ph;
    logic       rst, run, stl, br;
    logic [4:0] ba;
    m_pc = 5'd0; m_ir = 8'h00; m_v = 1'b0; m_init = 1'b0; m_boot = 1'b1; m_ph = 0;
    for (int n = 0; n < 400; n++) begin
      rst = (n < 2) || ($urandom_range(99) == 0);
      run = ($urandom_range(9) < 8);
      stl = ($urandom_range(9) < 3);
      br  = ($urandom_range(9) == 0);
      ba  = 5'($urandom_range(31));
      reset = rst; bus.run = run; bus.stall = stl; bus.branch_en = br; bus.branch_addr = ba;
      if (rst) begin
        m_pc = 5'd0; m_ir = 8'h00; m_v = 1'b0; m_init = 1'b0; m_boot = 1'b1; m_ph = 0;
      end else begin
        n_init = m_boot;
        m_boot = 1'b0;
        if (br) begin
          m_pc = ba; m_v = 1'b0;
          if (m_ph != 0) m_ph = run ? 1 : 0;
        end else if (m_ph == 0) begin
          if (run && !m_init) m_ph = 1;
        end else if (m_ph == 1) begin
          if (!(m_v && stl)) begin m_v = 1'b0; m_ph = run ? 2 : 0; end
        end else begin
          m_ir = 8'(m_pc); m_v = 1'b1; m_pc = m_pc + 5'd1; m_ph = 1;
        end
        m_init = n_init;
      end
      cyc();
      n_checks++; if (bus.pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc cyc=%0d got=%0d exp=%0d", n, bus.pc, m_pc); end
      n_checks++; if (bus.ir !== m_ir) begin n_fail++; $display("FAIL rnd_ir cyc=%0d got=%h exp=%h", n, bus.ir, m_ir); end
      n_checks++; if (bus.ir_valid !== m_v) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, bus.ir_valid, m_v); end
      n_checks++; if (bus.rom_init !== m_init) begin n_fail++; $display("FAIL rnd_init cyc=%0d got=%b exp=%b", n, bus.rom_init, m_init); end
      n_checks++; if (bus.rom_addr !== m_pc || bus.rom_we !== 1'b0) begin n_fail++; $display("FAIL rnd_rom cyc=%0d got addr=%0d we=%b exp addr=%0d we=0", n, bus.rom_addr, bus.rom_we, m_pc); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clock = 1'b0; reset = 1'b1; n_checks = 0; n_fail = 0;
    bus.run = 1'b0; bus.stall = 1'b0; bus.branch_en = 1'b0; bus.branch_addr = 5'd0;
`ifdef FETCH_BOOT_LOADER_EN
    bus.load_en = 1'b0; bus.load_data = 8'h00;
`endif
    test_reset();
    test_sequential();
    test_stall();
    test_branch_capture();
    test_wrap();
    test_run_drop_reset();
`ifdef FETCH_BOOT_LOADER_EN
    test_loader();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
